// File: rtl/icache_lookup_refill.sv
// Direct-mapped I-cache lookup stage with single-line refill and AHB two-cycle error response.
// Hits return one word per cycle; a miss stalls the bus until the line is refilled.
module icache_lookup_refill #(
  parameter int INDEX_BITS = 6,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] read_addr,
  input  logic [3:0]  read_offset,
  input  logic [1:0]  trans_in,
  input  logic        flush,
  output logic [31:0] hrdata,
  output logic        hready_out,
  output logic        hresp,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rerr
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 28 - INDEX_BITS;

  if (LINE_WORDS != 4) begin : g_bad_line_words
    $error("icache_lookup_refill: LINE_WORDS must be 4");
  end
  if (INDEX_BITS < 1 || INDEX_BITS > 27) begin : g_bad_index_bits
    $error("icache_lookup_refill: INDEX_BITS out of range");
  end

  typedef enum logic [2:0] {
    S_LOOKUP,
    S_MISS_REQ,
    S_REFILL,
    S_RESPOND,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t state, state_n;

  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [31:0]           data_mem [LINES][LINE_WORDS];
  logic [LINES-1:0]      valid;

  logic [TAG_BITS-1:0]   lat_tag;
  logic [INDEX_BITS-1:0] lat_index;
  logic [1:0]            lat_word;
  logic [1:0]            beat;
  logic                  flush_pend;

  logic [TAG_BITS-1:0]   acc_tag;
  logic [INDEX_BITS-1:0] acc_index;
  logic [1:0]            acc_word;
  logic                  accept;
  logic                  hit;
  logic                  beat_ok;
  logic                  unused_bits;

  assign acc_word    = read_offset[3:2];
  assign acc_index   = read_addr[3+INDEX_BITS:4];
  assign acc_tag     = read_addr[31:4+INDEX_BITS];
  assign unused_bits = ^{read_offset[1:0], read_addr[3:0]};

  // NONSEQ and SEQ both have trans_in[1] set.
  assign accept  = (state == S_LOOKUP) && hready_out && trans_in[1];
  assign hit     = valid[acc_index] && (tag_mem[acc_index] == acc_tag);
  assign beat_ok = (state == S_REFILL) && mem_rvalid && !mem_rerr;

  assign mem_addr = {lat_tag, lat_index, 4'h0};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_LOOKUP;
    else       state <= state_n;
  end

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_n    = state;
    hready_out = 1'b0;
    hresp      = 1'b0;
    mem_req    = 1'b0;
    case (state)
      S_LOOKUP: begin
        hready_out = 1'b1;
        if (accept && !hit) state_n = S_MISS_REQ;
      end
      S_MISS_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_n = S_REFILL;
      end
      S_REFILL: begin
        if (mem_rvalid) begin
          if (mem_rerr)          state_n = S_ERR1;
          else if (beat == 2'd3) state_n = S_RESPOND;
        end
      end
      S_RESPOND: begin
        hready_out = 1'b1;
        state_n    = S_LOOKUP;
      end
      S_ERR1: begin
        hresp   = 1'b1;
        state_n = S_ERR2;
      end
      S_ERR2: begin
        hresp      = 1'b1;
        hready_out = 1'b1;
        state_n    = S_LOOKUP;
      end
      default: state_n = S_LOOKUP;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hrdata     <= '0;
      valid      <= '0;
      lat_tag    <= '0;
      lat_index  <= '0;
      lat_word   <= '0;
      beat       <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (flush && state != S_LOOKUP) flush_pend <= 1'b1;
      case (state)
        S_LOOKUP: begin
          if (accept) begin
            if (hit) begin
              hrdata <= data_mem[acc_index][acc_word];
            end else begin
              lat_tag   <= acc_tag;
              lat_index <= acc_index;
              lat_word  <= acc_word;
            end
          end
          // Lookup above used the pre-flush bits; a missing line is invalidated
          // so a conflicting tag never matches partly overwritten data.
          if (flush)                valid            <= '0;
          else if (accept && !hit)  valid[acc_index] <= 1'b0;
        end
        S_MISS_REQ: beat <= '0;
        S_REFILL: begin
          if (beat_ok) begin
            beat <= beat + 2'd1;
            if (beat == 2'd3) begin
              valid[lat_index] <= 1'b1;
              hrdata <= (lat_word == 2'd3) ? mem_rdata : data_mem[lat_index][lat_word];
            end
          end
        end
        S_RESPOND, S_ERR2: begin
          if (flush || flush_pend) begin
            valid      <= '0;
            flush_pend <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (beat_ok) begin
      data_mem[lat_index][beat] <= mem_rdata;
      if (beat == 2'd3) tag_mem[lat_index] <= lat_tag;
    end
  end

endmodule

// File: tb/tb_icache_lookup_refill.sv
// Directed bench for icache_lookup_refill: table of hit/idle vectors plus
// hand-written miss, conflict, error, flush and reset-mid-refill sequences.
module tb_icache_lookup_refill;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_BUSY   = 2'd1;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] read_addr;
  logic [3:0]  read_offset;
  logic [1:0]  trans_in;
  logic        flush;
  logic [31:0] hrdata;
  logic        hready_out;
  logic        hresp;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rerr;

  int n_cmp  = 0;
  int n_fail = 0;

  icache_lookup_refill #(.INDEX_BITS(6), .LINE_WORDS(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .read_addr  (read_addr),
    .read_offset(read_offset),
    .trans_in   (trans_in),
    .flush      (flush),
    .hrdata     (hrdata),
    .hready_out (hready_out),
    .hresp      (hresp),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_rerr   (mem_rerr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        flush;
    logic [31:0] exp_hrdata;
    logic        exp_hready;
    logic        exp_mem_req;
  } vec_t;

  vec_t vecs[8];

  // Memory contents seen by the refill side: a word's value encodes its address.
  function automatic logic [31:0] model(input logic [31:0] a);
    return 32'hD000_0000 ^ {a[31:2], 2'b00};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic hit_check(input logic [31:0] addr, input logic [31:0] exp);
    read_addr = addr; read_offset = addr[3:0]; trans_in = T_NONSEQ;
    @(negedge clk);
    trans_in = T_IDLE;
    check("hit_hrdata", hrdata, exp);
    check("hit_hready", 32'(hready_out), 32'd1);
    check("hit_no_req", 32'(mem_req), 32'd0);
  endtask

  // One miss: request, grant after a wait cycle, four beats with a gap before
  // beat 2 (stray mem_rerr while mem_rvalid is low), optional error/flush beat.
  task automatic do_miss(input logic [31:0] addr, input int err_beat, input int flush_beat);
    logic [31:0] line;
    logic        aborted;
    line    = {addr[31:4], 4'h0};
    aborted = 1'b0;
    read_addr = addr; read_offset = addr[3:0]; trans_in = T_NONSEQ;
    @(negedge clk);
    check("miss_hready", 32'(hready_out), 32'd0);
    check("miss_req", 32'(mem_req), 32'd1);
    check("miss_addr", mem_addr, line);
    @(negedge clk);
    check("req_held", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("req_drop", 32'(mem_req), 32'd0);
    check("refill_hready", 32'(hready_out), 32'd0);
    for (int b = 0; b < 4 && !aborted; b++) begin
      if (b == 2) begin
        mem_rerr = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rerr = 1'b0;
        check("gap_hready", 32'(hready_out), 32'd0);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = model(line + 32'(4 * b));
      mem_rerr   = (b == err_beat);
      flush      = (b == flush_beat);
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rerr = 1'b0; flush = 1'b0;
      if (b == err_beat) aborted = 1'b1;
      else if (b < 3) check("beat_hready", 32'(hready_out), 32'd0);
    end
    trans_in = T_IDLE;
    if (aborted) begin
      check("err1_hresp", 32'(hresp), 32'd1);
      check("err1_hready", 32'(hready_out), 32'd0);
      mem_rvalid = 1'b1; mem_rdata = model(line + 32'd12);
      @(negedge clk);
      mem_rvalid = 1'b0;
      check("err2_hresp", 32'(hresp), 32'd1);
      check("err2_hready", 32'(hready_out), 32'd1);
      @(negedge clk);
      check("post_err_hresp", 32'(hresp), 32'd0);
      check("post_err_hready", 32'(hready_out), 32'd1);
    end else begin
      check("resp_hrdata", hrdata, model(addr));
      check("resp_hready", 32'(hready_out), 32'd1);
      check("resp_hresp", 32'(hresp), 32'd0);
      @(negedge clk);
      check("idle_hready", 32'(hready_out), 32'd1);
      check("idle_no_req", 32'(mem_req), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0108, T_SEQ,    1'b0, 32'hD000_0108, 1'b1, 1'b0};
    vecs[1] = '{32'h0000_010C, T_SEQ,    1'b0, 32'hD000_010C, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_0100, T_SEQ,    1'b0, 32'hD000_0100, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0104, T_IDLE,   1'b0, 32'hD000_0100, 1'b1, 1'b0};
    vecs[4] = '{32'h0000_0200, T_BUSY,   1'b0, 32'hD000_0100, 1'b1, 1'b0};
    vecs[5] = '{32'h0000_0104, T_NONSEQ, 1'b0, 32'hD000_0104, 1'b1, 1'b0};
    vecs[6] = '{32'h0000_010C, T_NONSEQ, 1'b1, 32'hD000_010C, 1'b1, 1'b0};
    vecs[7] = '{32'h0000_0104, T_IDLE,   1'b0, 32'hD000_010C, 1'b1, 1'b0};

    rstn = 1'b0; read_addr = '0; read_offset = '0; trans_in = T_IDLE; flush = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rerr = 1'b0;
    #2;
    check("rst_hrdata", hrdata, 32'd0);
    check("rst_hready", 32'(hready_out), 32'd1);
    check("rst_hresp", 32'(hresp), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Cold miss, word 1 requested.
    do_miss(32'h0000_0104, -1, -1);

    // Back-to-back hits, idle/busy hold, flush coinciding with a hit.
    foreach (vecs[i]) begin
      read_addr = vecs[i].addr; read_offset = vecs[i].addr[3:0];
      trans_in = vecs[i].trans; flush = vecs[i].flush;
      @(negedge clk);
      check($sformatf("vec%0d_hrdata", i), hrdata, vecs[i].exp_hrdata);
      check($sformatf("vec%0d_hready", i), 32'(hready_out), 32'(vecs[i].exp_hready));
      check($sformatf("vec%0d_mem_req", i), 32'(mem_req), 32'(vecs[i].exp_mem_req));
    end
    trans_in = T_IDLE; flush = 1'b0;
    // Line was flushed by vec6, so this misses.
    do_miss(32'h0000_0108, -1, -1);

    // Conflict: same index, different tag, evicts the 0x100 line.
    do_miss(32'h0000_1104, -1, -1);
    do_miss(32'h0000_0104, -1, -1);
    hit_check(32'h0000_0100, 32'hD000_0100);

    // Error on beat 2, then retry misses and refills cleanly.
    do_miss(32'h0000_0308, 2, -1);
    do_miss(32'h0000_0308, -1, -1);
    hit_check(32'h0000_030C, 32'hD000_030C);

    // Flush during refill: word still returned, line invalid afterwards.
    do_miss(32'h0000_040C, -1, 1);
    do_miss(32'h0000_0404, -1, -1);
    hit_check(32'h0000_0400, 32'hD000_0400);

    // Reset asserted during refill beat 1.
    read_addr = 32'h0000_2208; read_offset = 4'h8; trans_in = T_NONSEQ;
    @(negedge clk);
    check("rr_miss_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = model(32'h0000_2200);
    @(negedge clk);
    mem_rdata = model(32'h0000_2204);
    #1 rstn = 1'b0;
    #1;
    check("rr_mem_req", 32'(mem_req), 32'd0);
    check("rr_hready", 32'(hready_out), 32'd1);
    check("rr_hrdata", hrdata, 32'd0);
    trans_in = T_IDLE;
    @(negedge clk);
    rstn = 1'b1;
    mem_rdata = model(32'h0000_2208);
    @(negedge clk);
    mem_rdata = model(32'h0000_220C);
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("rr_late_hready", 32'(hready_out), 32'd1);
    check("rr_late_req", 32'(mem_req), 32'd0);
    check("rr_late_hrdata", hrdata, 32'd0);
    do_miss(32'h0000_2208, -1, -1);
    do_miss(32'h0000_0400, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
